peripheral_mpi_noc_loopback: RTL and testbench

//   Store-and-forward NoC loopback stage for peripheral_mpi_wb.
//   - Consumes packets from the MPI endpoint's noc_out_* port and swaps DEST/SRC in the header flit.
//   - Replays each packet into the endpoint's noc_in_* port.
//   - Lets a single-tile bench exercise MPI send and receive without a NoC.
//   - Buffers exactly one packet at a time.

---
 rtl/peripheral_mpi_noc_loopback.sv | 146 ++++++++++++++
 tb/tb_peripheral_mpi_noc_loopback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_mpi_noc_loopback.sv
// Store-and-forward NoC loopback: buffers one packet, swaps DEST/SRC in the header, replays it.
// Optional packet counter enabled by PERIPHERAL_MPI_LOOPBACK_STATS_EN.
module peripheral_mpi_noc_loopback #(
    parameter int NOC_FLIT_WIDTH = 32,
    parameter int DEST_WIDTH     = 5,
    parameter int CLASS_WIDTH    = 3,
    parameter int BUFFER_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NOC_FLIT_WIDTH-1:0] in_flit,
    input  logic                      in_last,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NOC_FLIT_WIDTH-1:0] out_flit,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overflow,
    output logic [15:0]               pkt_count
);

    localparam int PTR_W   = $clog2(BUFFER_DEPTH);
    localparam int SRC_MSB = NOC_FLIT_WIDTH - DEST_WIDTH - CLASS_WIDTH - 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(BUFFER_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DISCARD,
        DRAIN
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [NOC_FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [NOC_FLIT_WIDTH-1:0] hdr_swapped;
    logic                      rx_ok;
    logic                      in_xfer;
    logic                      out_xfer;
    logic                      trunc;

    always_comb begin
        hdr_swapped = in_flit;
        hdr_swapped[NOC_FLIT_WIDTH-1 -: DEST_WIDTH] = in_flit[SRC_MSB -: DEST_WIDTH];
        hdr_swapped[SRC_MSB -: DEST_WIDTH]          = in_flit[NOC_FLIT_WIDTH-1 -: DEST_WIDTH];
    end

    // Pointer wrap is intentional: a full buffer leaves wr_ptr at 0, so wr_ptr-1 still names the last slot.
    assign out_last = (rd_ptr == wr_ptr - PTR_W'(1));
    assign out_flit = mem[rd_ptr];
    assign rx_ok    = in_valid && !rst;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        trunc      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (rx_ok) begin
                    state_next = in_last ? DRAIN : FILL;
                end
            end
            FILL: begin
                in_ready = !rst;
                if (rx_ok) begin
                    if (in_last) begin
                        state_next = DRAIN;
                    end else if (wr_ptr == LAST_SLOT) begin
                        trunc      = 1'b1;
                        state_next = DISCARD;
                    end
                end
            end
            DISCARD: begin
                in_ready = !rst;
                if (rx_ok && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && out_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_xfer && state != DISCARD) begin
            mem[wr_ptr] <= (state == IDLE) ? hdr_swapped : in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= trunc;
            if (in_xfer && state != DISCARD) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (out_xfer) begin
                if (out_last) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

`ifdef PERIPHERAL_MPI_LOOPBACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (out_xfer && out_last) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_peripheral_mpi_noc_loopback.sv
// Bench for peripheral_mpi_noc_loopback: directed packets plus random traffic against a packet-level model.
module tb_peripheral_mpi_noc_loopback;

    typedef logic [31:0] flit_q [$];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;
    logic [15:0] pkt_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_cnt = 0;
    int unsigned ovf_total = 0;

    peripheral_mpi_noc_loopback #(
        .NOC_FLIT_WIDTH(32),
        .DEST_WIDTH(5),
        .CLASS_WIDTH(3),
        .BUFFER_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_last(in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .overflow(overflow),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_total <= ovf_total + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic abort_run(input string tag);
        errors++;
        $display("FAIL %s: wait bound expired", tag);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "aborted");
    endtask

    // Header rewrite: DEST and SRC fields exchange places, everything else kept.
    function automatic logic [31:0] swap_hdr(input logic [31:0] h);
        logic [31:0] dest, cls, src, rest;
        dest = (h >> 27) & 32'h1F;
        cls  = (h >> 24) & 32'h7;
        src  = (h >> 19) & 32'h1F;
        rest = h & 32'h7FFFF;
        return (src << 27) | (cls << 24) | (dest << 19) | rest;
    endfunction

    function automatic flit_q model(input flit_q pkt);
        flit_q r;
        int unsigned n;
        n = (pkt.size() > 16) ? 16 : pkt.size();
        for (int i = 0; i < int'(n); i++) r.push_back(pkt[i]);
        r[0] = swap_hdr(r[0]);
        return r;
    endfunction

    function automatic logic [15:0] exp_pkt_count();
`ifdef PERIPHERAL_MPI_LOOPBACK_STATS_EN
        return exp_cnt[15:0];
`else
        return 16'h0;
`endif
    endfunction

    task automatic send_pkt(input flit_q pkt, input bit gaps);
        int unsigned waits;
        bit          done;
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_flit  = pkt[i];
            in_last  = (i == pkt.size() - 1);
            done  = 1'b0;
            waits = 0;
            while (!done) begin
                @(negedge clk);
                chk("fill_out_valid", {31'b0, out_valid}, 32'd0);
                done = (in_ready === 1'b1);
                @(posedge clk); #1;
                waits++;
                if (!done && waits > 40) abort_run("send_wait");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling 1010..., 2: random
    task automatic recv_pkt(input flit_q exp, input int unsigned take, input int unsigned mode, input bit junk);
        int unsigned got, cyc;
        logic [31:0] pf;
        logic        pl;
        bit          stalled;
        got = 0; cyc = 0; stalled = 1'b0; pf = '0; pl = 1'b0;
        while (got < take) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (junk) begin
                in_valid = 1'b1;
                in_flit  = $urandom;
                in_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("drain_out_valid", {31'b0, out_valid}, 32'd1);
            if (junk) chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
            if (stalled) begin
                chk("stall_flit", out_flit, pf);
                chk("stall_last", {31'b0, out_last}, {31'b0, pl});
            end
            if (out_valid === 1'b1 && out_ready) begin
                chk("out_flit", out_flit, exp[got]);
                chk("out_last", {31'b0, out_last}, {31'b0, got == exp.size() - 1});
                got++;
                stalled = 1'b0;
            end else begin
                stalled = (out_valid === 1'b1);
                pf = out_flit;
                pl = out_last;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            cyc++;
            if (got < take && cyc > 200) abort_run("recv_wait");
        end
        out_ready = 1'b0;
    endtask

    task automatic run_pkt(input flit_q pkt, input flit_q exp, input bit gaps, input int unsigned mode, input bit junk);
        int unsigned ov0;
        ov0 = ovf_total;
        send_pkt(pkt, gaps);
        recv_pkt(exp, exp.size(), mode, junk);
        @(negedge clk);
        exp_cnt++;
        chk("end_busy", {31'b0, busy}, 32'd0);
        chk("end_out_valid", {31'b0, out_valid}, 32'd0);
        chk("end_in_ready", {31'b0, in_ready}, 32'd1);
        chk("pkt_count", {16'b0, pkt_count}, {16'b0, exp_pkt_count()});
        chk("overflow_pulses", ovf_total - ov0, (pkt.size() > 16) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        flit_q p, e;
        int unsigned len;

        rst = 1'b1; in_flit = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_overflow", {31'b0, overflow}, 32'd0);
        chk("reset_pkt_count", {16'b0, pkt_count}, 32'd0);
        @(posedge clk); #1;

        // basic 3-flit packet
        p = '{32'h1A280000, 32'hDEADBEEF, 32'h00000042};
        e = '{32'h2A180000, 32'hDEADBEEF, 32'h00000042};
        run_pkt(p, e, 1'b0, 0, 1'b0);

        // single flit
        p = '{32'h1A280000};
        e = '{32'h2A180000};
        run_pkt(p, e, 1'b0, 0, 1'b0);

        // backpressure with upstream trying to push during drain
        p = '{32'hF8123456, 32'h11111111, 32'h22222222, 32'h33333333};
        run_pkt(p, model(p), 1'b0, 1, 1'b1);

        // overflow: 20 flits in, 16 out
        p = {};
        for (int i = 0; i < 20; i++) p.push_back($urandom);
        run_pkt(p, model(p), 1'b0, 0, 1'b0);

        // exactly buffer depth: no truncation
        p = {};
        for (int i = 0; i < 16; i++) p.push_back($urandom);
        run_pkt(p, model(p), 1'b0, 2, 1'b0);

        // reset mid-drain after two flits delivered
        p = '{32'h0C0A0001, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
        send_pkt(p, 1'b0);
        recv_pkt(model(p), 2, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("post_rst_pkt_count", {16'b0, pkt_count}, 32'd0);
        @(posedge clk); #1;
        p = '{32'h9B470000, 32'hCAFEF00D, 32'h12345678};
        run_pkt(p, model(p), 1'b0, 0, 1'b0);

        // random traffic
        for (int k = 0; k < 12; k++) begin
            len = $urandom_range(1, 20);
            p = {};
            for (int i = 0; i < int'(len); i++) p.push_back($urandom);
            run_pkt(p, model(p), 1'b1, 2, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
